fft_bitrev_framer: RTL and testbench
====================================

FFT_BITREV_FRAMER -- requirements
Module: fft_bitrev_framer

Interface
REQ-001 Parameter N, default 4, is the FFT points per frame; it SHALL be a power of two and at least 2.
REQ-002 Parameter W, default 16, is the signed sample width of each real/imag component.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-004 Port reset, input, 1 bit: reset SHALL be asynchronous and active-low (0 = reset).
REQ-005 Port in_valid, input, 1 bit: the upstream sample is valid.
REQ-006 Port in_ready, output, 1 bit: the framer can accept a sample.
REQ-007 Port in_real / in_imag, input, W bits each, signed: the input sample in natural time order.
REQ-008 Port out_valid, input of downstream, output here, 1 bit: the output sample is valid.
REQ-009 Port out_ready, input, 1 bit: the downstream FFT accepts the sample.
REQ-010 Port out_real / out_imag, output, W bits each, signed: the sample in bit-reversed order.
REQ-011 Port out_index, output, log2(N) bits: the natural-order index of the sample on out_real/out_imag.
REQ-012 Port out_last, output, 1 bit: high with the final sample of a frame.

Function
REQ-013 The block SHALL hold two N-entry banks (ping-pong); each bank has a full flag.
REQ-014 in_ready SHALL equal NOT(full flag of the current write bank), driven combinationally from registered state.
REQ-015 An input transfer occurs when in_valid and in_ready are both 1 at a clock edge; the sample SHALL be written at the linear write count, and the count SHALL increment.
REQ-016 On the transfer at write count N-1, the write bank SHALL be marked full, the write count SHALL wrap to 0, and the write bank pointer SHALL toggle.
REQ-017 Read side states: IDLE (no full bank at the read pointer) and STREAM (draining the read bank).
REQ-018 IDLE->STREAM SHALL occur at the first edge where the read bank is full; the output register loads entry bitrev(0), and out_valid rises at that edge.
REQ-019 The output register SHALL update only when out_valid=0 or out_ready=1; data is held stable while out_valid=1 and out_ready=0.
REQ-020 In STREAM, the k-th accepted output SHALL carry bank[bitrev(k)], out_index=bitrev(k), and out_last=1 when k=N-1.
REQ-021 When the output at k=N-1 is accepted, the read bank full flag SHALL clear and the read pointer SHALL toggle.
REQ-022 If the other bank is already full at that edge, the read side SHALL stay in STREAM and load bitrev(0) of the next bank with no bubble; otherwise it SHALL go to IDLE with out_valid=0.
REQ-023 Latency: input sample N-1 accepted at edge t gives out_valid=1 with index 0 after edge t+1, when the read side is idle.
REQ-024 Simultaneous events: a full-flag set by the write side and a clear by the read side on different banks at the same edge SHALL both take effect.
REQ-025 A bank freed at edge t SHALL present in_ready=1 in the following cycle.
REQ-026 Sample values SHALL pass through unmodified, with no arithmetic and no width change.

Reset
REQ-027 While reset=0: write count=0, both pointers=bank 0, both full flags=0, state=IDLE, out_valid=0, out_last=0, out_index=0, out_real=0, out_imag=0.
REQ-028 A reset mid-frame SHALL discard all partial and complete frames; bank storage contents need not be cleared.
REQ-029 After reset deasserts, in_ready SHALL be 1 in the first cycle.

Structure
REQ-030 The shared package fft_pkg SHALL hold the defaults FFT_N=4 and FFT_W=16 and the bit-reverse function, for reuse by the fft stage.
REQ-031 One sub-module is natural: fft_pingpong_bank (an N-entry dual-port storage with one write port and one read port), instantiated twice.
REQ-032 Storage SHALL have no reset and be inferable as distributed RAM.

Verification
REQ-033 N=4, out_ready=1: in_real 10,20,30,40 -> out_real 10,30,20,40, out_index 0,2,1,3, out_last on the 4th, first out_valid one cycle after the 4th accept.
REQ-034 Two frames back-to-back (1..4, 5..8) with out_ready=1 -> out_real 1,3,2,4,5,7,6,8 with no out_valid gap between frames.
REQ-035 out_ready=0 held: 8 samples accepted, then in_ready=0; a 9th sample held is not accepted until the first frame fully drains.
REQ-036 out_ready toggling 1/0 each cycle -> order is unchanged, and each value is held stable while stalled.
REQ-037 reset pulsed low after 2 of 4 samples -> out_valid=0 and in_ready=1; a new frame 100..103 emits 100,102,101,103.
REQ-038 in_imag = -1,-2,-3,-4 (negative values) -> out_imag = -1,-3,-2,-4, with bits preserved exactly.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT definitions: default frame geometry, read-side states and the
// bit-reverse helper reused by the framer and later FFT stages.
package fft_pkg;

  localparam int unsigned FFT_N = 4;
  localparam int unsigned FFT_W = 16;

  typedef enum logic {
    RD_IDLE,
    RD_STREAM
  } rd_state_t;

  // Reverses the low 'bits' bits of v; higher result bits are zero.
  function automatic logic [31:0] bitrev(input logic [31:0] v, input int unsigned bits);
    logic [31:0] r;
    logic [31:0] t;
    r = '0;
    t = v;
    for (int unsigned i = 0; i < bits; i++) begin
      r = {r[30:0], t[0]};
      t = t >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_pingpong_bank.sv
// N-entry storage bank: one synchronous write port, one asynchronous read port,
// no reset so it maps onto distributed RAM.
module fft_pingpong_bank
  import fft_pkg::*;
#(
  parameter int unsigned N  = FFT_N,
  parameter int unsigned DW = 2 * FFT_W,
  localparam int unsigned AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [N];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fft_bitrev_framer.sv
// Ping-pong framer: collects N natural-order samples per bank and streams each
// full bank out in bit-reversed order with a valid/ready handshake.
module fft_bitrev_framer
  import fft_pkg::*;
#(
  parameter int unsigned N = FFT_N,
  parameter int unsigned W = FFT_W,
  localparam int unsigned AW = $clog2(N)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] in_real,
  input  logic signed [W-1:0] in_imag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] out_real,
  output logic signed [W-1:0] out_imag,
  output logic [AW-1:0]       out_index,
  output logic                out_last
);

  localparam int unsigned DW = 2 * W;

  rd_state_t     state, state_nx;
  logic [AW-1:0] wr_cnt;
  logic          wr_ptr, rd_ptr, rd_ptr_nx;
  logic [1:0]    full, full_nx;
  logic [AW-1:0] rd_k, rd_k_nx;
  logic          out_valid_q, out_valid_nx;
  logic [DW-1:0] out_data;

  logic          in_fire, wr_done, rd_clr, load, rd_sel;
  logic [1:0]    we;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rdata [2];

  assign in_ready = ~full[wr_ptr];
  assign in_fire  = in_valid & in_ready;
  assign wr_done  = in_fire && (wr_cnt == AW'(N - 1));
  assign we[0]    = in_fire & ~wr_ptr;
  assign we[1]    = in_fire & wr_ptr;

  fft_pingpong_bank #(.N(N), .DW(DW)) bank0 (
    .clk   (clk),
    .we    (we[0]),
    .waddr (wr_cnt),
    .wdata ({in_real, in_imag}),
    .raddr (rd_addr),
    .rdata (rdata[0])
  );

  fft_pingpong_bank #(.N(N), .DW(DW)) bank1 (
    .clk   (clk),
    .we    (we[1]),
    .waddr (wr_cnt),
    .wdata ({in_real, in_imag}),
    .raddr (rd_addr),
    .rdata (rdata[1])
  );

  // The read address is taken from the next k so the output register loads
  // the entry it will present, straight from the asynchronous read port.
  always_comb begin
    state_nx     = state;
    rd_ptr_nx    = rd_ptr;
    rd_k_nx      = rd_k;
    out_valid_nx = out_valid_q;
    rd_clr       = 1'b0;
    load         = 1'b0;
    rd_sel       = rd_ptr;
    unique case (state)
      RD_IDLE: begin
        if (full[rd_ptr]) begin
          state_nx     = RD_STREAM;
          rd_k_nx      = '0;
          load         = 1'b1;
          out_valid_nx = 1'b1;
        end
      end
      RD_STREAM: begin
        if (out_ready) begin
          if (rd_k == AW'(N - 1)) begin
            rd_clr    = 1'b1;
            rd_ptr_nx = ~rd_ptr;
            rd_k_nx   = '0;
            if (full[~rd_ptr]) begin
              load   = 1'b1;
              rd_sel = ~rd_ptr;
            end else begin
              state_nx     = RD_IDLE;
              out_valid_nx = 1'b0;
            end
          end else begin
            rd_k_nx = rd_k + AW'(1);
            load    = 1'b1;
          end
        end
      end
      default: state_nx = RD_IDLE;
    endcase
    rd_addr = AW'(bitrev(32'(rd_k_nx), AW));

    // Set and clear always target different banks, so both can apply together.
    full_nx = full;
    if (wr_done) full_nx[wr_ptr] = 1'b1;
    if (rd_clr)  full_nx[rd_ptr] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RD_IDLE;
      wr_cnt      <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      full        <= '0;
      rd_k        <= '0;
      out_valid_q <= 1'b0;
      out_data    <= '0;
    end else begin
      state       <= state_nx;
      rd_ptr      <= rd_ptr_nx;
      rd_k        <= rd_k_nx;
      out_valid_q <= out_valid_nx;
      full        <= full_nx;
      if (in_fire) begin
        wr_cnt <= wr_done ? '0 : wr_cnt + AW'(1);
        if (wr_done) wr_ptr <= ~wr_ptr;
      end
      if (load) out_data <= rd_sel ? rdata[1] : rdata[0];
    end
  end

  assign out_valid = out_valid_q;
  assign out_real  = out_data[DW-1:W];
  assign out_imag  = out_data[W-1:0];
  assign out_index = AW'(bitrev(32'(rd_k), AW));
  assign out_last  = out_valid_q && (rd_k == AW'(N - 1));

endmodule

// File: tb/tb_fft_bitrev_framer.sv
// Bench for fft_bitrev_framer: frame-level reference model compared every
// cycle, plus directed sequences with literal expected output orders.
module tb_fft_bitrev_framer;

  localparam int N  = 4;
  localparam int LG = 2;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [15:0] in_real = '0;
  logic signed [15:0] in_imag = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic signed [15:0] out_real;
  logic signed [15:0] out_imag;
  logic [1:0]         out_index;
  logic               out_last;

  fft_bitrev_framer #(.N(N), .W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_real   (in_real),
    .in_imag   (in_imag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_real  (out_real),
    .out_imag  (out_imag),
    .out_index (out_index),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [15:0] re;
    logic [15:0] im;
    int          idx;
    bit          last;
  } ent_t;

  ent_t        expq[$];
  logic [15:0] part_re[$];
  logic [15:0] part_im[$];
  int          pending   = 0;
  bit          just_done = 1'b0;

  logic [15:0] log_re[$];
  logic [15:0] log_im[$];
  int          log_idx[$];
  int          log_last[$];
  int          log_cyc[$];

  bit          prev_stall = 1'b0;
  logic [15:0] held_re, held_im;
  int          held_idx;

  function automatic int brev(input int k);
    int r = 0;
    for (int b = 0; b < LG; b++) r = r * 2 + (k / (2 ** b)) % 2;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Per-cycle model compare, sampled on the falling edge.
  always @(negedge clk) begin : model
    ent_t e;
    bit   exp_ov;
    cyc++;
    if (!reset) begin
      expq.delete(); part_re.delete(); part_im.delete();
      pending = 0; just_done = 1'b0; prev_stall = 1'b0;
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_last",  32'(out_last), 0);
      chk("rst_out_index", 32'(out_index), 0);
      chk("rst_out_real",  {16'h0, out_real}, 0);
      chk("rst_out_imag",  {16'h0, out_imag}, 0);
      chk("rst_in_ready",  32'(in_ready), 1);
    end else begin
      exp_ov = (pending > 0) && !(pending == 1 && just_done);
      chk("in_ready",  32'(in_ready), 32'(pending < 2));
      chk("out_valid", 32'(out_valid), 32'(exp_ov));
      if (out_valid && expq.size() > 0) begin
        e = expq[0];
        chk("out_real",  {16'h0, out_real}, {16'h0, e.re});
        chk("out_imag",  {16'h0, out_imag}, {16'h0, e.im});
        chk("out_index", 32'(out_index), 32'(e.idx));
        chk("out_last",  32'(out_last), 32'(e.last));
      end
      if (prev_stall) begin
        chk("hold_valid", 32'(out_valid), 1);
        chk("hold_real",  {16'h0, out_real}, {16'h0, held_re});
        chk("hold_imag",  {16'h0, out_imag}, {16'h0, held_im});
        chk("hold_index", 32'(out_index), 32'(held_idx));
      end
      just_done = 1'b0;
      if (out_valid && out_ready && expq.size() > 0) begin
        e = expq.pop_front();
        log_re.push_back(out_real);
        log_im.push_back(out_imag);
        log_idx.push_back(int'(out_index));
        log_last.push_back(int'(out_last));
        log_cyc.push_back(cyc);
        if (e.last) pending--;
      end
      if (in_valid && in_ready) begin
        part_re.push_back(in_real);
        part_im.push_back(in_imag);
        if (part_re.size() == N) begin
          for (int k = 0; k < N; k++) begin
            e.re   = part_re[brev(k)];
            e.im   = part_im[brev(k)];
            e.idx  = brev(k);
            e.last = (k == N - 1);
            expq.push_back(e);
          end
          part_re.delete(); part_im.delete();
          pending++;
          just_done = 1'b1;
        end
      end
      prev_stall = out_valid && !out_ready;
      held_re  = out_real;
      held_im  = out_imag;
      held_idx = int'(out_index);
    end
  end

  task automatic send(input logic [15:0] re, input logic [15:0] im);
    bit acc = 1'b0;
    in_real  = re;
    in_imag  = im;
    in_valid = 1'b1;
    for (int i = 0; i < 300 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("send_accepted", 32'(acc), 1);
  endtask

  task automatic clear_log();
    log_re.delete(); log_im.delete(); log_idx.delete(); log_last.delete(); log_cyc.delete();
  endtask

  // sel: 0 real, 1 imag, 2 index, 3 last
  task automatic check_log(input string nm, input int sel, input int n, input int ev[12]);
    int sz;
    sz = log_re.size();
    chk({nm, "_count"}, 32'(sz >= n), 1);
    for (int i = 0; i < n && i < sz; i++) begin
      case (sel)
        0:       chk({nm, "_real"},  {16'h0, log_re[i]}, {16'h0, 16'(ev[i])});
        1:       chk({nm, "_imag"},  {16'h0, log_im[i]}, {16'h0, 16'(ev[i])});
        2:       chk({nm, "_index"}, 32'(log_idx[i]), 32'(ev[i]));
        default: chk({nm, "_last"},  32'(log_last[i]), 32'(ev[i]));
      endcase
    end
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1 chk("post_reset_in_ready", 32'(in_ready), 1);

    // Single frame, latency and order.
    clear_log();
    out_ready = 1'b1;
    send(16'd10, 16'd0); send(16'd20, 16'd0); send(16'd30, 16'd0); send(16'd40, 16'd0);
    chk("lat_before", 32'(out_valid), 0);
    @(posedge clk); #1;
    chk("lat_after",  32'(out_valid), 1);
    chk("lat_index",  32'(out_index), 0);
    chk("lat_real",   {16'h0, out_real}, 32'd10);
    repeat (6) @(posedge clk); #1;
    check_log("t1", 0, 4, '{10, 30, 20, 40, 0, 0, 0, 0, 0, 0, 0, 0});
    check_log("t1", 2, 4, '{0, 2, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0});
    check_log("t1", 3, 4, '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0});

    // Back-to-back frames, no bubble between them.
    clear_log();
    for (int v = 1; v <= 8; v++) send(16'(v), 16'd0);
    repeat (8) @(posedge clk); #1;
    check_log("t2", 0, 8, '{1, 3, 2, 4, 5, 7, 6, 8, 0, 0, 0, 0});
    for (int i = 0; i + 1 < log_cyc.size(); i++)
      chk("t2_gap", 32'(log_cyc[i + 1] - log_cyc[i]), 1);

    // Both banks full under backpressure.
    clear_log();
    out_ready = 1'b0;
    for (int v = 11; v <= 18; v++) send(16'(v), 16'd0);
    chk("t3_full", 32'(in_ready), 0);
    in_real = 16'd19; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("t3_blocked", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    send(16'd19, 16'd0);
    chk("t3_drained_first", 32'(log_re.size() >= 4), 1);
    send(16'd20, 16'd0); send(16'd21, 16'd0); send(16'd22, 16'd0);
    repeat (10) @(posedge clk); #1;
    check_log("t3", 0, 12, '{11, 13, 12, 14, 15, 17, 16, 18, 19, 21, 20, 22});

    // out_ready toggling every cycle.
    clear_log();
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          @(posedge clk); #1;
          out_ready = ~out_ready;
        end
      end
      begin
        send(16'd31, 16'd0); send(16'd32, 16'd0); send(16'd33, 16'd0); send(16'd34, 16'd0);
      end
    join
    out_ready = 1'b1;
    repeat (8) @(posedge clk); #1;
    check_log("t4", 0, 4, '{31, 33, 32, 34, 0, 0, 0, 0, 0, 0, 0, 0});

    // Reset mid-frame discards the partial frame.
    clear_log();
    send(16'd50, 16'd0); send(16'd51, 16'd0);
    reset = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    chk("mid_rst_in_ready",  32'(in_ready), 1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    for (int v = 100; v <= 103; v++) send(16'(v), 16'd0);
    repeat (8) @(posedge clk); #1;
    check_log("t5", 0, 4, '{100, 102, 101, 103, 0, 0, 0, 0, 0, 0, 0, 0});

    // Negative imaginary parts pass bit-exact.
    clear_log();
    for (int v = 1; v <= 4; v++) send(16'(v), 16'(-v));
    repeat (8) @(posedge clk); #1;
    check_log("t6", 1, 4, '{-1, -3, -2, -4, 0, 0, 0, 0, 0, 0, 0, 0});
    check_log("t6", 0, 4, '{1, 3, 2, 4, 0, 0, 0, 0, 0, 0, 0, 0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
